// File: rtl/bram_loader.sv
// Byte-stream to 16-bit word loader for an SB_RAM40_4K word memory write port.
// Packs byte pairs from a valid/ready stream and writes them to consecutive addresses.
module bram_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned HIGH_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_CNT   = ADDR_W'(NUM_WORDS - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   count, count_next;
  logic [ADDR_W-1:0]   waddr_next;
  logic [DATA_W-1:0]   wdata_next;
  logic                we_q;
  logic                transfer;

  assign transfer = in_valid & in_ready;

  // abort must suppress the write of a word already in WRITE, so it gates the strobe directly
  assign we = we_q & ~abort;

  // next-state and datapath update
  always_comb begin
    state_next = state;
    count_next = count;
    waddr_next = waddr;
    wdata_next = wdata;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = BYTE0;
            waddr_next = FIRST_ADDR;
            count_next = '0;
          end
        end
        BYTE0: begin
          if (transfer) begin
            if (HIGH_FIRST != 0) wdata_next[15:8] = in_data;
            else                 wdata_next[7:0]  = in_data;
            state_next = BYTE1;
          end
        end
        BYTE1: begin
          if (transfer) begin
            if (HIGH_FIRST != 0) wdata_next[7:0]  = in_data;
            else                 wdata_next[15:8] = in_data;
            state_next = WRITE;
          end
        end
        WRITE: begin
          if (count == LAST_CNT) begin
            state_next = DONE;
          end else begin
            count_next = count + ADDR_W'(1);
            waddr_next = waddr + ADDR_W'(1);
            state_next = BYTE0;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // state, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      waddr    <= FIRST_ADDR;
      wdata    <= '0;
      in_ready <= 1'b0;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      waddr    <= waddr_next;
      wdata    <= wdata_next;
      in_ready <= (state_next == BYTE0) || (state_next == BYTE1);
      we_q     <= (state_next == WRITE);
      busy     <= (state_next == BYTE0) || (state_next == BYTE1) || (state_next == WRITE);
      done     <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed self-checking bench for bram_loader: three instances cover default,
// low-byte-first single-word and address-wrap configurations.
module tb_bram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       start_a, start_b, start_c;

  logic       rdy_a, we_a, busy_a, done_a;
  logic [7:0] waddr_a;
  logic [15:0] wdata_a;
  logic       rdy_b, we_b, busy_b, done_b;
  logic [7:0] waddr_b;
  logic [15:0] wdata_b;
  logic       rdy_c, we_c, busy_c, done_c;
  logic [7:0] waddr_c;
  logic [15:0] wdata_c;

  bram_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a)
  );

  bram_loader #(.NUM_WORDS(1), .HIGH_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b)
  );

  bram_loader #(.NUM_WORDS(4), .START_ADDR(8'hFE)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .busy(busy_c), .done(done_c)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 0;

  logic [7:0]  stream [512];
  logic [15:0] mem [256];
  int          we_cnt_a = 0, done_cnt_a = 0, addr_err_a = 0, rdy_err_a = 0, done_cyc_a = 0;
  logic [7:0]  exp_addr_a = 8'h00;
  int          we_cnt_b = 0, done_cnt_b = 0;
  logic [7:0]  last_addr_b = 8'h00;
  logic [15:0] last_data_b = 16'h0;
  int          we_cnt_c = 0, done_cnt_c = 0;
  logic [7:0]  addr_c [4];
  logic [15:0] data_c [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // BRAM models, sampled mid-cycle while the write strobe is stable
  always @(negedge clk) begin
    #2;
    if (we_a === 1'b1) begin
      if (waddr_a !== exp_addr_a) addr_err_a++;
      mem[waddr_a] = wdata_a;
      exp_addr_a = exp_addr_a + 8'd1;
      we_cnt_a++;
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (busy_a === 1'b1 && we_a === 1'b0 && abort === 1'b0 && rdy_a !== 1'b1) rdy_err_a++;
    if (we_b === 1'b1) begin
      last_addr_b = waddr_b;
      last_data_b = wdata_b;
      we_cnt_b++;
    end
    if (done_b === 1'b1) done_cnt_b++;
    if (we_c === 1'b1) begin
      if (we_cnt_c < 4) begin
        addr_c[we_cnt_c] = waddr_c;
        data_c[we_cnt_c] = wdata_c;
      end
      we_cnt_c++;
    end
    if (done_c === 1'b1) done_cnt_c++;
  end

  function automatic logic cur_ready();
    case (sel)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic cur_busy();
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Present stream[0..n-1]; returns at the negedge after the last transfer edge with in_valid low
  task automatic feed(input int n, input bit rnd);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 6000) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = stream[idx];
      #1;
      if (in_valid && cur_ready()) idx++;
      guard++;
    end
    if (idx < n) check_eq("feed_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (i < budget) begin
      @(negedge clk);
      #3;
      if (!cur_busy()) break;
      i++;
    end
    if (i >= budget) check_eq("idle_timeout", 32'(i), 32'(0));
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  initial begin
    int start_cyc;
    int errs;
    int we_before;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int i = 0; i < 512; i++) stream[i] = 8'(i);
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;

    // reset values
    #12;
    check_eq("rst_in_ready", 32'(rdy_a), 32'd0);
    check_eq("rst_we",       32'(we_a),  32'd0);
    check_eq("rst_waddr",    32'(waddr_a), 32'h00);
    check_eq("rst_wdata",    32'(wdata_a), 32'h0000);
    check_eq("rst_busy",     32'(busy_a), 32'd0);
    check_eq("rst_done",     32'(done_a), 32'd0);
    check_eq("rst_waddr_c",  32'(waddr_c), 32'hFE);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // test 1: full 256-word load, valid held high
    sel = 0;
    exp_addr_a = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    feed(512, 1'b0);
    wait_idle(20);
    repeat (2) @(negedge clk);
    check_eq("t1_we_count",   32'(we_cnt_a), 32'd256);
    check_eq("t1_done_count", 32'(done_cnt_a), 32'd1);
    check_eq("t1_addr_order", 32'(addr_err_a), 32'd0);
    check_eq("t1_word0",      32'(mem[0]), 32'h0001);
    check_eq("t1_word1",      32'(mem[1]), 32'h0203);
    check_eq("t1_word255",    32'(mem[255]), 32'hFEFF);
    check_eq("t1_latency_ge_768", 32'(done_cyc_a - start_cyc >= 768), 32'd1);
    check_eq("t1_waddr_last", 32'(waddr_a), 32'hFF);
    check_eq("t1_busy_after", 32'(busy_a), 32'd0);

    // test 2: same stream with random stalls
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    we_cnt_a = 0; done_cnt_a = 0; addr_err_a = 0; rdy_err_a = 0; exp_addr_a = 8'h00;
    pulse_start(0);
    feed(512, 1'b1);
    wait_idle(20);
    repeat (2) @(negedge clk);
    errs = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== {8'(2 * n), 8'(2 * n + 1)}) errs++;
    check_eq("t2_contents",   32'(errs), 32'd0);
    check_eq("t2_we_count",   32'(we_cnt_a), 32'd256);
    check_eq("t2_done_count", 32'(done_cnt_a), 32'd1);
    check_eq("t2_ready_held", 32'(rdy_err_a), 32'd0);
    check_eq("t2_addr_order", 32'(addr_err_a), 32'd0);

    // test 3: low byte first, single word
    sel = 1;
    stream[0] = 8'h34;
    stream[1] = 8'h12;
    pulse_start(1);
    feed(2, 1'b0);
    wait_idle(10);
    repeat (2) @(negedge clk);
    check_eq("t3_wdata",  32'(last_data_b), 32'h1234);
    check_eq("t3_waddr",  32'(last_addr_b), 32'h00);
    check_eq("t3_we_cnt", 32'(we_cnt_b), 32'd1);
    check_eq("t3_done",   32'(done_cnt_b), 32'd1);

    // test 4: address wrap from 0xFE
    sel = 2;
    for (int i = 0; i < 8; i++) stream[i] = 8'(i);
    pulse_start(2);
    feed(8, 1'b0);
    wait_idle(10);
    repeat (2) @(negedge clk);
    check_eq("t4_we_cnt", 32'(we_cnt_c), 32'd4);
    check_eq("t4_addr0",  32'(addr_c[0]), 32'hFE);
    check_eq("t4_addr1",  32'(addr_c[1]), 32'hFF);
    check_eq("t4_addr2",  32'(addr_c[2]), 32'h00);
    check_eq("t4_addr3",  32'(addr_c[3]), 32'h01);
    check_eq("t4_data2",  32'(data_c[2]), 32'h0405);
    check_eq("t4_done",   32'(done_cnt_c), 32'd1);

    // test 5: abort during the WRITE of word 5
    sel = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < 12; i++) stream[i] = 8'(i);
    we_cnt_a = 0; done_cnt_a = 0; addr_err_a = 0; exp_addr_a = 8'h00;
    pulse_start(0);
    feed(12, 1'b0);
    abort = 1'b1;
    #1;
    check_eq("t5_we_gated", 32'(we_a), 32'd0);
    check_eq("t5_words_written", 32'(we_cnt_a), 32'd5);
    @(negedge clk);
    abort = 1'b0;
    #3;
    check_eq("t5_busy_after", 32'(busy_a), 32'd0);
    check_eq("t5_no_done", 32'(done_cnt_a), 32'd0);
    check_eq("t5_word4", 32'(mem[4]), 32'h0809);
    check_eq("t5_word5_unwritten", 32'(mem[5]), 32'hDEAD);
    stream[0] = 8'hA1;
    stream[1] = 8'hB2;
    exp_addr_a = 8'h00;
    pulse_start(0);
    feed(2, 1'b0);
    #1;
    check_eq("t5_restart_we",    32'(we_a), 32'd1);
    check_eq("t5_restart_waddr", 32'(waddr_a), 32'h00);
    check_eq("t5_restart_wdata", 32'(wdata_a), 32'hA1B2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_a = 1'b0;
    #1;
    check_eq("t5_abort_beats_start", 32'(busy_a), 32'd0);

    // test 6: start while busy, then async reset mid-pair
    stream[0] = 8'h77;
    pulse_start(0);
    feed(1, 1'b0);
    we_before = we_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    check_eq("t6_busy_start_ignored", 32'(busy_a), 32'd1);
    check_eq("t6_still_byte1", 32'(rdy_a), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_in_ready", 32'(rdy_a), 32'd0);
    check_eq("t6_rst_waddr",    32'(waddr_a), 32'h00);
    check_eq("t6_rst_wdata",    32'(wdata_a), 32'h0000);
    check_eq("t6_rst_busy",     32'(busy_a), 32'd0);
    check_eq("t6_rst_we_done",  32'({we_a, done_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check_eq("t6_no_partial_write", 32'(we_cnt_a), 32'(we_before));
    check_eq("t6_idle_after", 32'(busy_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
